// File: rtl/stream_reduce_pkg.sv
// Shared constants for the stream reduction unit: reduction modes and FSM state encoding.
package stream_reduce_pkg;

    localparam int REDUCE_SUM = 0;
    localparam int REDUCE_MIN = 1;
    localparam int REDUCE_MAX = 2;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_ACCUM = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_e;

endpackage

// File: rtl/stream_reduce_alu.sv
// Combinational reduction step: op(acc, x) for sum/min/max with optional signedness
// and saturation; flags arithmetic overflow in sum mode only.
module stream_reduce_alu
    import stream_reduce_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int MODE   = REDUCE_SUM,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] x_i,
    output logic [ACC_W-1:0] res_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] UMAX = '1;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0]          sum_w;
    logic                    sum_ovf;
    logic                    x_lt;
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] x_s;

    always_comb begin
        acc_s = acc_i;
        x_s   = x_i;
        sum_w = {1'b0, acc_i} + {1'b0, x_i};
        // Signed overflow: operands agree in sign but the truncated sum does not.
        if (SIGNED != 0) begin
            sum_ovf = (acc_i[ACC_W-1] == x_i[ACC_W-1]) && (sum_w[ACC_W-1] != acc_i[ACC_W-1]);
            x_lt    = (x_s < acc_s);
        end else begin
            sum_ovf = sum_w[ACC_W];
            x_lt    = (x_i < acc_i);
        end

        res_o = acc_i;
        ovf_o = 1'b0;
        case (MODE)
            REDUCE_SUM: begin
                res_o = sum_w[ACC_W-1:0];
                ovf_o = sum_ovf;
                if (sum_ovf && (SAT != 0)) begin
                    if (SIGNED != 0)
                        res_o = acc_i[ACC_W-1] ? SMIN : SMAX;
                    else
                        res_o = UMAX;
                end
            end
            REDUCE_MIN: res_o = x_lt ? x_i : acc_i;
            REDUCE_MAX: res_o = x_lt ? acc_i : x_i;
            default:    res_o = acc_i;
        endcase
    end

endmodule

// File: rtl/stream_reduce.sv
// Stream reduction unit: accepts a job, folds each stream beat into an accumulator
// and presents the reduced value, element count and sticky overflow until consumed.
module stream_reduce
    import stream_reduce_pkg::*;
#(
    parameter int N      = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 16,
    parameter int MODE   = REDUCE_SUM,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [N-1:0]     s_in,
    input  logic             s_in_valid,
    output logic             s_in_ready,
    input  logic             s_in_last,
    output logic [ACC_W-1:0] result,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [ACC_W-1:0] UMAX = '1;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] IDENT =
        (MODE == REDUCE_MIN) ? ((SIGNED != 0) ? SMAX : UMAX) :
        (MODE == REDUCE_MAX) ? ((SIGNED != 0) ? SMIN : '0)   : '0;

    sr_state_e        state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic signed [N-1:0] s_in_s;
    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    alu_res;
    logic                alu_ovf;

    always_comb begin
        s_in_s = s_in;
        if (SIGNED != 0)
            x_ext = ACC_W'(s_in_s);
        else
            x_ext = ACC_W'(s_in);
    end

    stream_reduce_alu #(
        .ACC_W  (ACC_W),
        .MODE   (MODE),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_alu (
        .acc_i (acc_q),
        .x_i   (x_ext),
        .res_o (alu_res),
        .ovf_o (alu_ovf)
    );

    always_comb begin
        acc_d = alu_res;
        ovf_d = ovf_q | alu_ovf;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= SR_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                SR_IDLE: begin
                    if (in_valid) begin
                        state_q <= SR_ACCUM;
                        acc_q   <= IDENT;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                SR_ACCUM: begin
                    if (s_in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (s_in_last)
                            state_q <= SR_DONE;
                    end
                end
                SR_DONE: begin
                    if (out_ready)
                        state_q <= SR_IDLE;
                end
                default: state_q <= SR_IDLE;
            endcase
        end
    end

    // Outputs are decodes of registered state, forced low while reset is held.
    always_comb begin
        in_ready   = nrst && (state_q == SR_IDLE);
        s_in_ready = nrst && (state_q == SR_ACCUM);
        out_valid  = nrst && (state_q == SR_DONE);
        result     = nrst ? acc_q : '0;
        count      = nrst ? cnt_q : '0;
        overflow   = nrst && ovf_q;
    end

endmodule
